pix_burst_wr: RTL and testbench
===============================

PIX_BURST_WR -- requirements
Module: pix_burst_wr

Interface
REQ-001 Parameters (name, default, meaning): BURST_LEN, 16, words per write burst.
REQ-002 FIFO_DEPTH, 64, internal pixel FIFO depth in words; a power of 2 and at least 2*BURST_LEN.
REQ-003 FRAME_WORDS, 307200, words per frame; an integer multiple of BURST_LEN.
REQ-004 BASE_ADDR, 24'h000000, word address of the first pixel of each frame.
REQ-005 sys_clk  in  1  the single clock for all logic; rising edge.
REQ-006 sys_rst  in  1  reset; asynchronous and active-high.
REQ-007 pix_vsync  in  1  frame sync from the camera capture stage; a rising edge marks a frame start.
REQ-008 pix_wr_en  in  1  qualifies pix_data; one 16-bit pixel per asserted cycle.
REQ-009 pix_data  in  16  RGB565 pixel.
REQ-010 wr_req  out  1  burst write request to the memory controller.
REQ-011 wr_addr  out  24  start word address of the requested burst; stable while wr_req is high.
REQ-012 wr_ack  in  1  memory controller grant; sampled only while wr_req is high.
REQ-013 wr_data_vld  out  1  high for exactly BURST_LEN consecutive cycles per granted burst.
REQ-014 wr_data  out  16  burst data word, valid when wr_data_vld is high.
REQ-015 frame_done  out  1  one-cycle pulse after the last burst of a frame completes.
REQ-016 ovf_err  out  1  sticky flag; set when a pixel is dropped, cleared on a pix_vsync rising edge.

Function
REQ-017 The block SHALL detect a pix_vsync rising edge from a registered copy of pix_vsync, giving one cycle of detection latency.
REQ-018 The block SHALL write a pixel into the FIFO on each pix_wr_en cycle when the FIFO is not full and the frame word count is below FRAME_WORDS.
REQ-019 The block SHALL drop a pixel and set ovf_err when the FIFO is full or the frame already holds FRAME_WORDS words.
REQ-020 The state machine SHALL have exactly three states: IDLE, REQ and DATA.
REQ-021 IDLE -> REQ SHALL occur when the FIFO count is at least BURST_LEN and no flush is pending; wr_req SHALL be registered and go high the next cycle.
REQ-022 In REQ, wr_req SHALL stay high until wr_ack is sampled high; REQ -> DATA SHALL then occur and wr_req SHALL drop in the same edge.
REQ-023 wr_data_vld SHALL rise on the first cycle of DATA.
REQ-024 In DATA, the block SHALL emit BURST_LEN FIFO words in write order, one per cycle, with no gaps; the memory controller provides no backpressure.
REQ-025 At the end of a burst the state SHALL be DATA -> IDLE, and wr_addr SHALL advance by BURST_LEN.
REQ-026 When a burst completes the frame's FRAME_WORDS words, frame_done SHALL pulse for one cycle and wr_addr SHALL return to BASE_ADDR.
REQ-027 Flush on a vsync edge in IDLE or REQ: the block SHALL clear the FIFO, reset wr_addr and the frame count, drop wr_req, go to IDLE, and clear ovf_err.
REQ-028 Flush on a vsync edge in DATA: the current burst SHALL complete in full, and the flush SHALL then execute on the first IDLE cycle.
REQ-029 A pixel arriving in the flush cycle SHALL belong to the new frame and SHALL be written after the clear, leaving a FIFO count of 1.
REQ-030 A simultaneous FIFO read and write SHALL leave the count unchanged; the FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 A vsync edge during a partial frame SHALL NOT cause a frame_done pulse.

Reset
REQ-032 While sys_rst is high, the block SHALL hold: state IDLE, FIFO empty, wr_req=0, wr_addr=BASE_ADDR, wr_data_vld=0, wr_data=0, frame_done=0, ovf_err=0, vsync history=0.
REQ-033 Reset asserted mid-burst SHALL abort the burst immediately; the next burst after release SHALL start at BASE_ADDR.

Verification
REQ-034 Stimulus: 16 pixels 0x0000..0x000F, wr_ack given 3 cycles after wr_req rises. Response: wr_addr=0x000000; wr_data_vld high 16 cycles; data 0x0000..0x000F in order; next burst wr_addr=0x000010.
REQ-035 Stimulus: FRAME_WORDS=64, 64 pixels, wr_ack held high. Response: four bursts at addresses 0x00, 0x10, 0x20, 0x30; one frame_done pulse after the 4th burst; wr_addr returns to 0x00.
REQ-036 Stimulus: wr_ack held low, 70 consecutive pixels. Response: FIFO holds 64; ovf_err=1 from the 65th pixel; after a vsync edge, ovf_err=0 and FIFO empty.
REQ-037 Stimulus: vsync rising edge during DATA word 5 of 16. Response: all 16 words emitted; flush executes next; the following burst starts at BASE_ADDR; no frame_done pulse.
REQ-038 Stimulus: vsync edge coincident with pix_wr_en during REQ. Response: wr_req drops; FIFO count=1; state IDLE.
REQ-039 Stimulus: sys_rst pulsed high mid-burst. Response: wr_data_vld=0 and wr_req=0 immediately; after release the first burst is at 0x000000.

Source files
------------

// File: rtl/pix_burst_wr_if.sv
// Pixel-in / burst-out signal bundle for the frame burst writer.
// The master view belongs to the burst writer. The slave view belongs to the
// camera capture stage and the memory controller that surround it.
interface pix_burst_wr_if;
  logic        pix_vsync;
  logic        pix_wr_en;
  logic [15:0] pix_data;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic        wr_ack;
  logic        wr_data_vld;
  logic [15:0] wr_data;
  logic        frame_done;
  logic        ovf_err;

  modport master (
    input  pix_vsync, pix_wr_en, pix_data, wr_ack,
    output wr_req, wr_addr, wr_data_vld, wr_data, frame_done, ovf_err
  );

  modport slave (
    output pix_vsync, pix_wr_en, pix_data, wr_ack,
    input  wr_req, wr_addr, wr_data_vld, wr_data, frame_done, ovf_err
  );
endinterface

// File: rtl/pix_burst_wr.sv
// Frame burst writer.
// Incoming RGB565 pixels are buffered in a FIFO. Each time BURST_LEN words are
// available, one burst write is requested. A granted burst is streamed out
// without gaps. A rising edge on vsync flushes the partial frame. If a burst
// is in flight, the flush waits until that burst has finished.
module pix_burst_wr #(
  parameter int unsigned BURST_LEN   = 16,
  parameter int unsigned FIFO_DEPTH  = 64,
  parameter int unsigned FRAME_WORDS = 307200,
  parameter logic [23:0] BASE_ADDR   = 24'h000000
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  pix_burst_wr_if.master bus
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned FRM_W  = $clog2(FRAME_WORDS + 1);
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  localparam logic [CNT_W-1:0]  FIFO_FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  BURST_CNT       = CNT_W'(BURST_LEN);
  localparam logic [FRM_W-1:0]  FRAME_CNT       = FRM_W'(FRAME_WORDS);
  localparam logic [BEAT_W-1:0] LAST_BEAT       = BEAT_W'(BURST_LEN - 1);
  // Start address of the burst that completes a frame.
  localparam logic [23:0]       LAST_BURST_ADDR = BASE_ADDR + 24'(FRAME_WORDS - BURST_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic                r_vsync_q;
  logic                w_vsync_rise;
  logic                r_flush_pend;
  logic                w_flush;

  logic [15:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    w_wr_idx;
  logic [CNT_W-1:0]    r_fifo_cnt;
  logic [FRM_W-1:0]    r_frame_cnt;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;

  logic [BEAT_W-1:0]   r_beat;
  logic                w_burst_end;

  logic                r_wr_req;
  logic [23:0]         r_wr_addr;
  logic                r_wr_data_vld;
  logic [15:0]         r_wr_data;
  logic                r_frame_done;
  logic                r_ovf_err;

  // A vsync edge is found by comparing the pin with last cycle's copy.
  assign w_vsync_rise = bus.pix_vsync & ~r_vsync_q;

  // A burst in progress is never cut short. A flush is therefore only taken
  // outside DATA, either straight from the edge or from the pending flag.
  assign w_flush = (r_state != ST_DATA) && (w_vsync_rise || r_flush_pend);

  assign w_full = (r_fifo_cnt == FIFO_FULL_CNT);

  // During a flush the FIFO and the frame count restart from zero. A pixel
  // arriving in that cycle is the first word of the new frame.
  assign w_push = bus.pix_wr_en &&
                  (w_flush || (!w_full && (r_frame_cnt < FRAME_CNT)));
  assign w_drop = bus.pix_wr_en && !w_push;

  // A pixel pushed during a flush goes into slot 0 of the emptied FIFO.
  assign w_wr_idx = w_flush ? '0 : r_wr_ptr;

  // Next-state logic and FIFO pops.
  // The first word is popped on the grant, so it is already on the output
  // register in the first DATA cycle.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_burst_end  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_flush && (r_fifo_cnt >= BURST_CNT)) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_flush) begin
          w_state_next = ST_IDLE;
        end else if (bus.wr_ack) begin
          w_state_next = ST_DATA;
          w_pop        = 1'b1;
        end
      end
      ST_DATA: begin
        if (r_beat == LAST_BEAT) begin
          w_state_next = ST_IDLE;
          w_burst_end  = 1'b1;
        end else begin
          w_pop = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State register, beat counter and vsync history.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= ST_IDLE;
      r_beat    <= '0;
      r_vsync_q <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_vsync_q <= bus.pix_vsync;
      if ((r_state == ST_DATA) && !w_burst_end) begin
        r_beat <= r_beat + BEAT_W'(1);
      end else begin
        r_beat <= '0;
      end
    end
  end

  // Remember a vsync edge seen mid-burst until the burst has drained.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_flush_pend <= 1'b0;
    end else if (w_flush) begin
      r_flush_pend <= 1'b0;
    end else if (w_vsync_rise) begin
      r_flush_pend <= 1'b1;
    end
  end

  // Pixel storage. This is write-only here, with no reset, so it maps to block RAM.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[w_wr_idx] <= bus.pix_data;
    end
  end

  // FIFO pointers, occupancy, and the count of words accepted this frame.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_fifo_cnt  <= '0;
      r_frame_cnt <= '0;
    end else if (w_flush) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= w_push ? PTR_W'(1) : '0;
      r_fifo_cnt  <= w_push ? CNT_W'(1) : '0;
      r_frame_cnt <= w_push ? FRM_W'(1) : '0;
    end else begin
      if (w_push) begin
        r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
        r_frame_cnt <= r_frame_cnt + FRM_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // Registered read port. It doubles as the burst data output register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_data     <= '0;
      r_wr_data_vld <= 1'b0;
    end else begin
      r_wr_data_vld <= w_pop;
      if (w_pop) begin
        r_wr_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // Request line follows the next state so that it comes from a flop.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_req <= 1'b0;
    end else begin
      r_wr_req <= (w_state_next == ST_REQ);
    end
  end

  // Burst address tracking and end-of-frame detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_addr    <= BASE_ADDR;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_flush) begin
        r_wr_addr <= BASE_ADDR;
      end else if (w_burst_end) begin
        if (r_wr_addr == LAST_BURST_ADDR) begin
          r_wr_addr    <= BASE_ADDR;
          r_frame_done <= 1'b1;
        end else begin
          r_wr_addr <= r_wr_addr + 24'(BURST_LEN);
        end
      end
    end
  end

  // Sticky overflow flag. A flush starts a fresh frame and clears it.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_ovf_err <= 1'b0;
    end else if (w_flush) begin
      r_ovf_err <= 1'b0;
    end else if (w_drop) begin
      r_ovf_err <= 1'b1;
    end
  end

  assign bus.wr_req      = r_wr_req;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data_vld = r_wr_data_vld;
  assign bus.wr_data     = r_wr_data;
  assign bus.frame_done  = r_frame_done;
  assign bus.ovf_err     = r_ovf_err;

endmodule

// File: tb/tb_pix_burst_wr.sv
// Directed testbench for pix_burst_wr, with FRAME_WORDS set to 64.
module tb_pix_burst_wr;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;

  pix_burst_wr_if bus ();

  pix_burst_wr #(
    .BURST_LEN  (16),
    .FIFO_DEPTH (64),
    .FRAME_WORDS(64),
    .BASE_ADDR  (24'h000000)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_pixels(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.pix_wr_en = 1'b1;
      bus.pix_data  = first + 16'(i);
      tick();
    end
    bus.pix_wr_en = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.wr_req === 1'b1) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic vsync_pulse();
    bus.pix_vsync = 1'b1;
    tick();
    bus.pix_vsync = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL reset_wr_req got=%0b exp=0", bus.wr_req); end
    n_cmp++; if (bus.wr_addr !== 24'h0) begin n_err++; $display("FAIL reset_wr_addr got=%h exp=000000", bus.wr_addr); end
    n_cmp++; if (bus.wr_data_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got=%0b exp=0", bus.wr_data_vld); end
    n_cmp++; if (bus.wr_data !== 16'h0) begin n_err++; $display("FAIL reset_wr_data got=%h exp=0000", bus.wr_data); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got=%0b exp=0", bus.frame_done); end
    n_cmp++; if (bus.ovf_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%0b exp=0", bus.ovf_err); end
    n_cmp++; if (dut.r_fifo_cnt !== 7'd0) begin n_err++; $display("FAIL reset_fifo_cnt got=%0d exp=0", dut.r_fifo_cnt); end
    sys_rst = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic test_single_burst();
    bit ok;
    push_pixels(16'h0000, 16);
    wait_req(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL b1_req got=timeout exp=wr_req"); end
    n_cmp++; if (bus.wr_addr !== 24'h000000) begin n_err++; $display("FAIL b1_addr got=%h exp=000000", bus.wr_addr); end
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (bus.wr_req !== 1'b1 || bus.wr_addr !== 24'h0) begin n_err++; $display("FAIL b1_req_hold c=%0d got req=%0b addr=%h exp req=1 addr=000000", c, bus.wr_req, bus.wr_addr); end
    end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (bus.wr_data_vld !== 1'b1 || bus.wr_data !== 16'(k)) begin n_err++; $display("FAIL b1_word k=%0d got vld=%0b data=%h exp vld=1 data=%h", k, bus.wr_data_vld, bus.wr_data, 16'(k)); end
      n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL b1_req_in_data k=%0d got=%0b exp=0", k, bus.wr_req); end
      tick();
    end
    n_cmp++; if (bus.wr_data_vld !== 1'b0) begin n_err++; $display("FAIL b1_vld_end got=%0b exp=0", bus.wr_data_vld); end
    n_cmp++; if (bus.wr_addr !== 24'h000010) begin n_err++; $display("FAIL b1_next_addr got=%h exp=000010", bus.wr_addr); end
    $display("burst addr=000000 words=16");
    push_pixels(16'h0010, 16);
    wait_req(ok);
    n_cmp++; if (!ok || bus.wr_addr !== 24'h000010) begin n_err++; $display("FAIL b2_addr got ok=%0b addr=%h exp ok=1 addr=000010", ok, bus.wr_addr); end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (bus.wr_data_vld !== 1'b1 || bus.wr_data !== 16'(16 + k)) begin n_err++; $display("FAIL b2_word k=%0d got vld=%0b data=%h exp vld=1 data=%h", k, bus.wr_data_vld, bus.wr_data, 16'(16 + k)); end
      tick();
    end
    $display("burst addr=000010 words=16");
    vsync_pulse();
    n_cmp++; if (bus.wr_addr !== 24'h0) begin n_err++; $display("FAIL b2_flush_addr got=%h exp=000000", bus.wr_addr); end
  endtask

  task automatic test_frame();
    logic [23:0] addrs[$];
    logic [15:0] words[$];
    int          n_done = 0;
    logic [23:0] addr_at_done = 24'hFFFFFF;
    bit          prev_req = 1'b0;
    bus.wr_ack = 1'b1;
    fork
      push_pixels(16'h0100, 64);
      begin
        for (int c = 0; c < 120; c++) begin
          tick();
          if (bus.wr_req && !prev_req) addrs.push_back(bus.wr_addr);
          prev_req = bus.wr_req;
          if (bus.wr_data_vld) words.push_back(bus.wr_data);
          if (bus.frame_done) begin
            n_done++;
            addr_at_done = bus.wr_addr;
          end
        end
      end
    join
    bus.wr_ack = 1'b0;
    n_cmp++; if (addrs.size() != 4) begin n_err++; $display("FAIL frame_bursts got=%0d exp=4", addrs.size()); end
    for (int i = 0; i < addrs.size(); i++) begin
      $display("burst addr=%h", addrs[i]);
      n_cmp++; if (addrs[i] !== 24'(16 * i)) begin n_err++; $display("FAIL frame_addr i=%0d got=%h exp=%h", i, addrs[i], 24'(16 * i)); end
    end
    n_cmp++; if (words.size() != 64) begin n_err++; $display("FAIL frame_words got=%0d exp=64", words.size()); end
    for (int i = 0; i < words.size(); i++) begin
      n_cmp++; if (words[i] !== 16'h0100 + 16'(i)) begin n_err++; $display("FAIL frame_data i=%0d got=%h exp=%h", i, words[i], 16'h0100 + 16'(i)); end
    end
    n_cmp++; if (n_done != 1) begin n_err++; $display("FAIL frame_done_pulses got=%0d exp=1", n_done); end
    n_cmp++; if (addr_at_done !== 24'h0) begin n_err++; $display("FAIL frame_addr_wrap got=%h exp=000000", addr_at_done); end
    vsync_pulse();
  endtask

  task automatic test_overflow();
    bus.wr_ack = 1'b0;
    for (int i = 0; i < 70; i++) begin
      bus.pix_wr_en = 1'b1;
      bus.pix_data  = 16'h0200 + 16'(i);
      tick();
      if (i == 63) begin
        n_cmp++; if (bus.ovf_err !== 1'b0) begin n_err++; $display("FAIL ovf_at_64 got=%0b exp=0", bus.ovf_err); end
      end
      if (i == 64) begin
        n_cmp++; if (bus.ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_at_65 got=%0b exp=1", bus.ovf_err); end
      end
    end
    bus.pix_wr_en = 1'b0;
    $display("overflow burst of 70 pixels pushed");
    n_cmp++; if (dut.r_fifo_cnt !== 7'd64) begin n_err++; $display("FAIL ovf_fifo_cnt got=%0d exp=64", dut.r_fifo_cnt); end
    n_cmp++; if (bus.ovf_err !== 1'b1 || bus.wr_req !== 1'b1) begin n_err++; $display("FAIL ovf_hold got ovf=%0b req=%0b exp ovf=1 req=1", bus.ovf_err, bus.wr_req); end
    bus.pix_vsync = 1'b1;
    tick();
    bus.pix_vsync = 1'b0;
    n_cmp++; if (bus.ovf_err !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%0b exp=0", bus.ovf_err); end
    n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL ovf_flush_req got=%0b exp=0", bus.wr_req); end
    n_cmp++; if (dut.r_fifo_cnt !== 7'd0) begin n_err++; $display("FAIL ovf_flush_cnt got=%0d exp=0", dut.r_fifo_cnt); end
    tick();
  endtask

  task automatic test_flush_in_data();
    bit ok;
    push_pixels(16'h0300, 20);
    wait_req(ok);
    n_cmp++; if (!ok || bus.wr_addr !== 24'h0) begin n_err++; $display("FAIL fd_req got ok=%0b addr=%h exp ok=1 addr=000000", ok, bus.wr_addr); end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (bus.wr_data_vld !== 1'b1 || bus.wr_data !== 16'h0300 + 16'(k) || bus.frame_done !== 1'b0) begin n_err++; $display("FAIL fd_word k=%0d got vld=%0b data=%h done=%0b exp vld=1 data=%h done=0", k, bus.wr_data_vld, bus.wr_data, bus.frame_done, 16'h0300 + 16'(k)); end
      bus.pix_vsync = (k == 5);
      tick();
    end
    bus.pix_vsync = 1'b0;
    $display("burst addr=000000 words=16 with vsync at word 5");
    n_cmp++; if (bus.wr_data_vld !== 1'b0 || bus.wr_addr !== 24'h000010 || dut.r_fifo_cnt !== 7'd4) begin n_err++; $display("FAIL fd_burst_end got vld=%0b addr=%h cnt=%0d exp vld=0 addr=000010 cnt=4", bus.wr_data_vld, bus.wr_addr, dut.r_fifo_cnt); end
    tick();
    n_cmp++; if (bus.wr_addr !== 24'h0 || dut.r_fifo_cnt !== 7'd0) begin n_err++; $display("FAIL fd_flush got addr=%h cnt=%0d exp addr=000000 cnt=0", bus.wr_addr, dut.r_fifo_cnt); end
    n_cmp++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL fd_no_done got=%0b exp=0", bus.frame_done); end
    tick();
    n_cmp++; if (bus.wr_req !== 1'b0 || bus.frame_done !== 1'b0) begin n_err++; $display("FAIL fd_idle got req=%0b done=%0b exp req=0 done=0", bus.wr_req, bus.frame_done); end
    push_pixels(16'h0400, 16);
    wait_req(ok);
    n_cmp++; if (!ok || bus.wr_addr !== 24'h0) begin n_err++; $display("FAIL fd_next_addr got ok=%0b addr=%h exp ok=1 addr=000000", ok, bus.wr_addr); end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (bus.wr_data_vld !== 1'b1 || bus.wr_data !== 16'h0400 + 16'(k)) begin n_err++; $display("FAIL fd_next_word k=%0d got vld=%0b data=%h exp vld=1 data=%h", k, bus.wr_data_vld, bus.wr_data, 16'h0400 + 16'(k)); end
      tick();
    end
    $display("burst addr=000000 words=16 after flush");
  endtask

  task automatic test_flush_in_req();
    bit ok;
    push_pixels(16'h0500, 16);
    wait_req(ok);
    n_cmp++; if (!ok || bus.wr_addr !== 24'h000010) begin n_err++; $display("FAIL fr_req got ok=%0b addr=%h exp ok=1 addr=000010", ok, bus.wr_addr); end
    bus.pix_vsync = 1'b1;
    bus.pix_wr_en = 1'b1;
    bus.pix_data  = 16'h05AA;
    tick();
    bus.pix_vsync = 1'b0;
    bus.pix_wr_en = 1'b0;
    $display("vsync with pixel during request");
    n_cmp++; if (bus.wr_req !== 1'b0) begin n_err++; $display("FAIL fr_req_drop got=%0b exp=0", bus.wr_req); end
    n_cmp++; if (dut.r_fifo_cnt !== 7'd1) begin n_err++; $display("FAIL fr_fifo_cnt got=%0d exp=1", dut.r_fifo_cnt); end
    n_cmp++; if (2'(dut.r_state) !== 2'd0) begin n_err++; $display("FAIL fr_state got=%0d exp=0", 2'(dut.r_state)); end
    n_cmp++; if (bus.wr_addr !== 24'h0) begin n_err++; $display("FAIL fr_addr got=%h exp=000000", bus.wr_addr); end
    push_pixels(16'h0600, 15);
    wait_req(ok);
    n_cmp++; if (!ok || bus.wr_addr !== 24'h0) begin n_err++; $display("FAIL fr_next_addr got ok=%0b addr=%h exp ok=1 addr=000000", ok, bus.wr_addr); end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      logic [15:0] exp_w;
      exp_w = (k == 0) ? 16'h05AA : 16'h0600 + 16'(k - 1);
      n_cmp++; if (bus.wr_data_vld !== 1'b1 || bus.wr_data !== exp_w) begin n_err++; $display("FAIL fr_word k=%0d got vld=%0b data=%h exp vld=1 data=%h", k, bus.wr_data_vld, bus.wr_data, exp_w); end
      tick();
    end
    $display("burst addr=000000 words=16 first=05aa");
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    push_pixels(16'h0700, 32);
    wait_req(ok);
    n_cmp++; if (!ok || bus.wr_addr !== 24'h000010) begin n_err++; $display("FAIL rm_req got ok=%0b addr=%h exp ok=1 addr=000010", ok, bus.wr_addr); end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.wr_data_vld !== 1'b1 || bus.wr_data !== 16'h0700 + 16'(k)) begin n_err++; $display("FAIL rm_word k=%0d got vld=%0b data=%h exp vld=1 data=%h", k, bus.wr_data_vld, bus.wr_data, 16'h0700 + 16'(k)); end
      tick();
    end
    sys_rst = 1'b1;
    #1;
    $display("reset asserted mid-burst");
    n_cmp++; if (bus.wr_data_vld !== 1'b0 || bus.wr_req !== 1'b0) begin n_err++; $display("FAIL rm_abort got vld=%0b req=%0b exp vld=0 req=0", bus.wr_data_vld, bus.wr_req); end
    tick();
    sys_rst = 1'b0;
    tick();
    n_cmp++; if (bus.wr_addr !== 24'h0 || dut.r_fifo_cnt !== 7'd0) begin n_err++; $display("FAIL rm_after got addr=%h cnt=%0d exp addr=000000 cnt=0", bus.wr_addr, dut.r_fifo_cnt); end
    push_pixels(16'h0800, 16);
    wait_req(ok);
    n_cmp++; if (!ok || bus.wr_addr !== 24'h0) begin n_err++; $display("FAIL rm_next_addr got ok=%0b addr=%h exp ok=1 addr=000000", ok, bus.wr_addr); end
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
    for (int k = 0; k < 16; k++) begin
      n_cmp++; if (bus.wr_data_vld !== 1'b1 || bus.wr_data !== 16'h0800 + 16'(k)) begin n_err++; $display("FAIL rm_next_word k=%0d got vld=%0b data=%h exp vld=1 data=%h", k, bus.wr_data_vld, bus.wr_data, 16'h0800 + 16'(k)); end
      tick();
    end
    $display("burst addr=000000 words=16 after reset");
  endtask

  initial begin
    bus.pix_vsync = 1'b0;
    bus.pix_wr_en = 1'b0;
    bus.pix_data  = 16'h0;
    bus.wr_ack    = 1'b0;
    test_reset();
    test_single_burst();
    test_frame();
    test_overflow();
    test_flush_in_data();
    test_flush_in_req();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
